// File: rtl/router_pkt_src.sv
// Upstream packet source for the 1x3 router: buffers host payload bytes and frames header/payload/parity.
// Optional parity error injection is enabled by defining ROUTER_PKT_SRC_ERR_INJ_EN.
module router_pkt_src #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_wr,
  input  logic [7:0]    host_data,
  output logic          host_full,
  output logic [AW:0]   fifo_count,
  input  logic          send,
  input  logic [1:0]    dest_addr,
  input  logic [5:0]    payload_len,
`ifdef ROUTER_PKT_SRC_ERR_INJ_EN
  input  logic          inj_err,
`endif
  output logic          send_ack,
  output logic          send_rej,
  output logic          idle,
  output logic          packet_valid,
  output logic [7:0]    datain,
  input  logic          busy,
  output logic          pkt_done,
  output logic [15:0]   pkts_sent
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY
  } state_t;

  state_t          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   rd_nxt;
  logic [AW:0]     count_q, count_d;
  logic            push, pop;

  logic [5:0]      len_q;
  logic [5:0]      rem_q;
  logic [7:0]      parity_q;
  logic [7:0]      parity_nxt;
  logic            inj_q;
  logic            inj_sel;
  logic            accept;

  logic            send_ack_q, send_rej_q, idle_q, packet_valid_q, pkt_done_q;
  logic [7:0]      datain_q;
  logic [15:0]     pkts_sent_q;

`ifdef ROUTER_PKT_SRC_ERR_INJ_EN
  assign inj_sel = inj_err;
`else
  assign inj_sel = 1'b0;
`endif

  // ---------------- payload FIFO ----------------
  assign host_full  = (count_q == (AW+1)'(DEPTH));
  assign fifo_count = count_q;
  assign push       = host_wr && !host_full;
  assign pop        = (state_q == S_PAYLOAD) && !busy;
  assign rd_nxt     = rd_ptr_q + AW'(1);

  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_nxt;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; flushing the pointers and count is enough to empty the FIFO.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= host_data;
  end

  // ---------------- framing FSM ----------------
  assign accept     = (dest_addr != 2'd3) && (payload_len != 6'd0) &&
                      (count_q >= (AW+1)'(payload_len));
  assign parity_nxt = parity_q ^ datain_q;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      rem_q          <= '0;
      parity_q       <= '0;
      inj_q          <= 1'b0;
      send_ack_q     <= 1'b0;
      send_rej_q     <= 1'b0;
      idle_q         <= 1'b1;
      packet_valid_q <= 1'b0;
      datain_q       <= '0;
      pkt_done_q     <= 1'b0;
      pkts_sent_q    <= '0;
    end else begin
      send_ack_q <= 1'b0;
      send_rej_q <= 1'b0;
      pkt_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (send) begin
            if (accept) begin
              len_q          <= payload_len;
              inj_q          <= inj_sel;
              send_ack_q     <= 1'b1;
              idle_q         <= 1'b0;
              packet_valid_q <= 1'b1;
              datain_q       <= {payload_len, dest_addr};
              state_q        <= S_HEADER;
            end else begin
              send_rej_q <= 1'b1;
            end
          end
        end
        S_HEADER: begin
          if (!busy) begin
            parity_q <= datain_q;
            rem_q    <= len_q;
            datain_q <= mem_q[rd_ptr_q];
            state_q  <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!busy) begin
            parity_q <= parity_nxt;
            rem_q    <= rem_q - 6'd1;
            if (rem_q == 6'd1) begin
              // Last payload byte leaves: present the parity byte with valid low.
              datain_q       <= inj_q ? ~parity_nxt : parity_nxt;
              packet_valid_q <= 1'b0;
              state_q        <= S_PARITY;
            end else begin
              datain_q <= mem_q[rd_nxt];
            end
          end
        end
        S_PARITY: begin
          if (!busy) begin
            pkt_done_q  <= 1'b1;
            pkts_sent_q <= pkts_sent_q + 16'd1;
            datain_q    <= '0;
            idle_q      <= 1'b1;
            inj_q       <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign send_ack     = send_ack_q;
  assign send_rej     = send_rej_q;
  assign idle         = idle_q;
  assign packet_valid = packet_valid_q;
  assign datain       = datain_q;
  assign pkt_done     = pkt_done_q;
  assign pkts_sent    = pkts_sent_q;

endmodule

// File: tb/tb_router_pkt_src.sv
// Directed self-checking bench for router_pkt_src: framing, back-pressure, rejection, FIFO wrap, reset.
module tb_router_pkt_src;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset, host_wr, send, busy;
  logic [7:0]    host_data;
  logic [1:0]    dest_addr;
  logic [5:0]    payload_len;
  logic          host_full, send_ack, send_rej, idle, packet_valid, pkt_done;
  logic [AW:0]   fifo_count;
  logic [7:0]    datain;
  logic [15:0]   pkts_sent;
`ifdef ROUTER_PKT_SRC_ERR_INJ_EN
  logic          inj_err;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  logic [7:0] rx_data[$];
  logic       rx_pv[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_all[$];
  int         cyc;

  router_pkt_src #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .host_wr      (host_wr),
    .host_data    (host_data),
    .host_full    (host_full),
    .fifo_count   (fifo_count),
    .send         (send),
    .dest_addr    (dest_addr),
    .payload_len  (payload_len),
`ifdef ROUTER_PKT_SRC_ERR_INJ_EN
    .inj_err      (inj_err),
`endif
    .send_ack     (send_ack),
    .send_rej     (send_rej),
    .idle         (idle),
    .packet_valid (packet_valid),
    .datain       (datain),
    .busy         (busy),
    .pkt_done     (pkt_done),
    .pkts_sent    (pkts_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic write_byte(input logic [7:0] b);
    host_wr   = 1'b1;
    host_data = b;
    tick();
    host_wr   = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
    send        = 1'b1;
    dest_addr   = a;
    payload_len = l;
    tick();
    send = 1'b0;
  endtask

  // Collects consumed bytes until pkt_done; busy follows busy_mask bit per cycle.
  task automatic recv(input logic [31:0] busy_mask, output int cycles);
    logic [7:0] pd;
    logic       pp, b, done;
    rx_data.delete();
    rx_pv.delete();
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 200) begin
      b    = (cycles < 32) ? busy_mask[cycles] : 1'b0;
      busy = b;
      pd   = datain;
      pp   = packet_valid;
      tick();
      cycles++;
      if (b) begin
        check("hold_data", datain, pd);
        check("hold_pv", packet_valid, pp);
      end else begin
        rx_data.push_back(pd);
        rx_pv.push_back(pp);
      end
      if (pkt_done) done = 1'b1;
    end
    busy = 1'b0;
    if (!done) check("pkt_done_timeout", 0, 1);
  endtask

  task automatic verify(input string tag, input logic [7:0] hdr, input logic [7:0] par);
    check({tag, "_nbytes"}, rx_data.size(), exp_q.size() + 2);
    if (rx_data.size() == exp_q.size() + 2) begin
      check({tag, "_hdr"}, rx_data[0], hdr);
      check({tag, "_hdr_pv"}, rx_pv[0], 1);
      for (int i = 0; i < exp_q.size(); i++) begin
        check($sformatf("%s_pay%0d", tag, i), rx_data[i+1], exp_q[i]);
        check($sformatf("%s_pay_pv%0d", tag, i), rx_pv[i+1], 1);
      end
      check({tag, "_parity"}, rx_data[exp_q.size()+1], par);
      check({tag, "_parity_pv"}, rx_pv[exp_q.size()+1], 0);
    end
  endtask

  function automatic logic [7:0] calc_parity(input logic [7:0] hdr);
    logic [7:0] p;
    p = hdr;
    foreach (exp_q[i]) p ^= exp_q[i];
    return p;
  endfunction

  task automatic load_basic();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      write_byte(8'h11 + 8'(i));
      exp_q.push_back(8'h11 + 8'(i));
    end
  endtask

  initial begin
    reset = 1'b1; host_wr = 1'b0; host_data = '0; send = 1'b0;
    dest_addr = '0; payload_len = '0; busy = 1'b0;
`ifdef ROUTER_PKT_SRC_ERR_INJ_EN
    inj_err = 1'b0;
`endif
    do_reset();

    // Reset values
    check("rst_pv", packet_valid, 0);
    check("rst_datain", datain, 0);
    check("rst_idle", idle, 1);
    check("rst_ack", send_ack, 0);
    check("rst_rej", send_rej, 0);
    check("rst_done", pkt_done, 0);
    check("rst_pkts", pkts_sent, 0);
    check("rst_count", fifo_count, 0);
    check("rst_full", host_full, 0);

    // Basic send: header 0x20, parity 0x28, pkt_done 10 cycles after ack
    load_basic();
    check("basic_count", fifo_count, 8);
    send_cmd(2'd0, 6'd8);
    check("basic_ack", send_ack, 1);
    check("basic_rej", send_rej, 0);
    check("basic_idle", idle, 0);
    check("basic_pv0", packet_valid, 1);
    check("basic_hdr_now", datain, 8'h20);
    recv(32'h0, cyc);
    check("basic_latency", cyc, 10);
    verify("basic", 8'h20, 8'h28);
    check("basic_pkts", pkts_sent, 1);
    check("basic_count_end", fifo_count, 0);
    check("basic_idle_end", idle, 1);

    // Back-pressure: 3 stalls on the header, 2 stalls on payload byte 3
    load_basic();
    send_cmd(2'd0, 6'd8);
    check("bp_ack", send_ack, 1);
    recv(32'h0000_0187, cyc);
    check("bp_latency", cyc, 15);
    verify("bp", 8'h20, 8'h28);
    check("bp_pkts", pkts_sent, 2);

    // Rejections leave the FIFO untouched
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      write_byte(8'h31 + 8'(i));
      exp_q.push_back(8'h31 + 8'(i));
    end
    send_cmd(2'd3, 6'd4);
    check("rej_addr3", send_rej, 1);
    check("rej_addr3_ack", send_ack, 0);
    check("rej_addr3_idle", idle, 1);
    tick();
    check("rej_pulse_width", send_rej, 0);
    send_cmd(2'd1, 6'd0);
    check("rej_len0", send_rej, 1);
    send_cmd(2'd1, 6'd5);
    check("rej_short", send_rej, 1);
    check("rej_short_pv", packet_valid, 0);
    check("rej_count", fifo_count, 4);
    send_cmd(2'd1, 6'd4);
    check("rej_then_ack", send_ack, 1);
    recv(32'h0, cyc);
    verify("rej_pkt", 8'h11, calc_parity(8'h11));

    // FIFO full, dropped writes, and read pointer wrap
    do_reset();
    exp_all.delete();
    for (int i = 0; i < 70; i++) begin
      write_byte(8'(i) ^ 8'h5A);
      if (i < 64) exp_all.push_back(8'(i) ^ 8'h5A);
      if (i == 62) check("full_63", host_full, 0);
      if (i == 63) check("full_64", host_full, 1);
    end
    check("full_count", fifo_count, 64);
    exp_q = exp_all[0:62];
    send_cmd(2'd2, 6'd63);
    check("wrap_ack63", send_ack, 1);
    recv(32'h0, cyc);
    verify("wrap63", 8'hFE, calc_parity(8'hFE));
    check("wrap_count1", fifo_count, 1);
    exp_q.delete();
    exp_q.push_back(exp_all[63]);
    send_cmd(2'd1, 6'd1);
    check("wrap_ack1", send_ack, 1);
    recv(32'h0, cyc);
    verify("wrap1", 8'h05, calc_parity(8'h05));
    check("wrap_count0", fifo_count, 0);
    exp_q.delete();
    write_byte(8'hC1); exp_q.push_back(8'hC1);
    write_byte(8'hC2); exp_q.push_back(8'hC2);
    send_cmd(2'd0, 6'd2);
    recv(32'h0, cyc);
    verify("wrap2", 8'h08, calc_parity(8'h08));

    // Reset in the middle of payload byte 4; send while busy is ignored
    do_reset();
    load_basic();
    send_cmd(2'd0, 6'd8);
    send = 1'b1; dest_addr = 2'd1; payload_len = 6'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("busy_send_ack", send_ack, 0);
      check("busy_send_rej", send_rej, 0);
    end
    send = 1'b0;
    check("mid_byte4", datain, 8'h14);
    check("mid_pv", packet_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_pv", packet_valid, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_datain", datain, 0);
    tick();
    reset = 1'b0;
    tick();
    check("mid_idle", idle, 1);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      write_byte(8'hA1 + 8'(i));
      exp_q.push_back(8'hA1 + 8'(i));
    end
    send_cmd(2'd1, 6'd3);
    check("mid_fresh_ack", send_ack, 1);
    recv(32'h0, cyc);
    verify("mid_fresh", 8'h0D, calc_parity(8'h0D));
    check("mid_pkts", pkts_sent, 1);

`ifdef ROUTER_PKT_SRC_ERR_INJ_EN
    // Inverted parity when injection is latched, clean parity afterwards
    do_reset();
    load_basic();
    inj_err = 1'b1;
    send_cmd(2'd0, 6'd8);
    inj_err = 1'b0;
    recv(32'h0, cyc);
    verify("inj", 8'h20, 8'hD7);
    load_basic();
    send_cmd(2'd0, 6'd8);
    recv(32'h0, cyc);
    verify("noinj", 8'h20, 8'h28);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
